// File: rtl/data_mem_responder_if.sv
// Load/store bus between the processor core (master) and the data-memory
// responder (slave). Groups request, response and tohost status signals.
interface data_mem_responder_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        AlignErr;
    logic        Done;
    logic [31:0] DoneValue;

    modport master (
        output MemWrite, MemRead, DataAdr, WriteData,
        input  ReadData, Ready, AlignErr, Done, DoneValue
    );

    modport slave (
        input  MemWrite, MemRead, DataAdr, WriteData,
        output ReadData, Ready, AlignErr, Done, DoneValue
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the processor load/store port.
// Word reads/writes complete after WAIT_STATES wait cycles with a one-cycle
// Ready pulse. Misaligned accesses complete with AlignErr and no side effect.
// Optional feature macro: DMEM_TOHOST_EN adds a sticky tohost Done/DoneValue
// capture of the first aligned write to TOHOST_ADDR.
module data_mem_responder #(
    parameter int          DEPTH_LOG2  = 6,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] TOHOST_ADDR = 32'd100
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               isWrite_q, isWrite_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0]        mem [DEPTH];

    logic [DEPTH_LOG2-1:0] wordIdx;
    logic               aligned;
    logic               respValid;
    logic               memWe;

    // Transaction state register; reset aborts any in-flight access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            isWrite_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            isWrite_q <= isWrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Next-state logic: latch the request in IDLE, count wait states, then respond once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        isWrite_d = isWrite_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.MemWrite || bus.MemRead) begin
                    isWrite_d = bus.MemWrite;
                    addr_d    = bus.DataAdr;
                    wdata_d   = bus.WriteData;
                    cnt_d     = CNT_W'(WAIT_STATES);
                    state_d   = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wordIdx   = addr_q[DEPTH_LOG2+1:2];
    assign aligned   = (addr_q[1:0] == 2'b00);
    assign respValid = (state_q == RESP);
    assign memWe     = respValid && isWrite_q && aligned;

    assign bus.Ready    = respValid;
    assign bus.AlignErr = respValid && !aligned;
    assign bus.ReadData = (respValid && !isWrite_q && aligned) ? mem[wordIdx] : 32'h0;

    // Word array; contents survive reset, a write lands at the end of its response cycle.
    always_ff @(posedge clk) begin
        if (reset && memWe) begin
            mem[wordIdx] <= wdata_q;
        end
    end

`ifdef DMEM_TOHOST_EN
    logic        done_q, done_d;
    logic [31:0] doneValue_q, doneValue_d;

    // Sticky tohost flag and the value of the first store that set it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            done_q      <= 1'b0;
            doneValue_q <= '0;
        end else begin
            done_q      <= done_d;
            doneValue_q <= doneValue_d;
        end
    end

    // Capture only the first aligned store to the tohost address.
    always_comb begin
        done_d      = done_q;
        doneValue_d = doneValue_q;
        if (memWe && (addr_q == TOHOST_ADDR) && !done_q) begin
            done_d      = 1'b1;
            doneValue_d = wdata_q;
        end
    end

    assign bus.Done      = done_q;
    assign bus.DoneValue = doneValue_q;
`else
    logic unusedTohost;

    assign unusedTohost  = ^{addr_q[31:DEPTH_LOG2+2], TOHOST_ADDR};
    assign bus.Done      = 1'b0;
    assign bus.DoneValue = 32'h0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (WAIT_STATES=2, DEPTH_LOG2=6).
// Honours DMEM_TOHOST_EN the same way the design does.
module tb_data_mem_responder;
    logic clk;
    logic reset;
    int   testCount;
    int   failCount;

    data_mem_responder_if busIf ();

    data_mem_responder #(
        .DEPTH_LOG2  (6),
        .WAIT_STATES (2),
        .TOHOST_ADDR (32'd100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one request at a falling edge, wait (bounded) for Ready, then drop the request.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] adr,
                                 input logic [31:0] data, output logic [31:0] rdata,
                                 output logic alignErr, output int latency);
        logic got;
        got      = 1'b0;
        rdata    = '0;
        alignErr = 1'b0;
        latency  = 0;
        @(negedge clk);
        busIf.MemWrite  = wr;
        busIf.MemRead   = rd;
        busIf.DataAdr   = adr;
        busIf.WriteData = data;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            latency++;
            if (busIf.Ready) begin
                got      = 1'b1;
                rdata    = busIf.ReadData;
                alignErr = busIf.AlignErr;
            end
        end
        busIf.MemWrite = 1'b0;
        busIf.MemRead  = 1'b0;
        if (!got) begin
            checkOutput("ready timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic writeWord(input string tag, input logic [31:0] adr, input logic [31:0] data);
        logic [31:0] rdata;
        logic        alignErr;
        int          latency;
        applyStimulus(1'b1, 1'b0, adr, data, rdata, alignErr, latency);
        checkOutput({tag, " wr latency"}, 32'(latency), 32'd3);
        checkOutput({tag, " wr alignerr"}, {31'd0, alignErr}, 32'd0);
    endtask

    task automatic readWord(input string tag, input logic [31:0] adr, input logic [31:0] expected);
        logic [31:0] rdata;
        logic        alignErr;
        int          latency;
        applyStimulus(1'b0, 1'b1, adr, 32'h0, rdata, alignErr, latency);
        checkOutput({tag, " rd data"}, rdata, expected);
        checkOutput({tag, " rd alignerr"}, {31'd0, alignErr}, 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        logic [31:0] rdata;
        logic        alignErr;
        int          latency;
        int          waitCycles;

        testCount       = 0;
        failCount       = 0;
        reset           = 1'b0;
        busIf.MemWrite  = 1'b0;
        busIf.MemRead   = 1'b1;
        busIf.DataAdr   = 32'h0;
        busIf.WriteData = 32'h0;

        // Reset held with a pending read: no response while reset is low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t1 reset ready", {31'd0, busIf.Ready}, 32'd0);
            checkOutput("t1 reset rdata", busIf.ReadData, 32'd0);
        end
        checkOutput("t1 reset alignerr", {31'd0, busIf.AlignErr}, 32'd0);
        checkOutput("t1 reset done", {31'd0, busIf.Done}, 32'd0);
        checkOutput("t1 reset donevalue", busIf.DoneValue, 32'd0);
        reset      = 1'b1;
        waitCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waitCycles++;
            if (busIf.Ready) break;
        end
        busIf.MemRead = 1'b0;
        checkOutput("t1 first ready cycle", 32'(waitCycles), 32'd3);

        // Plain write then read back.
        writeWord("t2", 32'h64, 32'h7);
        readWord("t2", 32'h64, 32'h7);

        // Upper address bits are ignored: 0x104 aliases word 1.
        writeWord("t3", 32'h104, 32'hA5A5);
        readWord("t3", 32'h004, 32'hA5A5);

        // Misaligned write is suppressed and flagged.
        writeWord("t4", 32'h64, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h66, 32'h9, rdata, alignErr, latency);
        checkOutput("t4 misaligned wr alignerr", {31'd0, alignErr}, 32'd1);
        checkOutput("t4 misaligned wr latency", 32'(latency), 32'd3);
        readWord("t4", 32'h64, 32'h1);
        applyStimulus(1'b0, 1'b1, 32'h65, 32'h0, rdata, alignErr, latency);
        checkOutput("t4 misaligned rd data", rdata, 32'd0);
        checkOutput("t4 misaligned rd alignerr", {31'd0, alignErr}, 32'd1);

        // Both strobes high is treated as a write.
        applyStimulus(1'b1, 1'b1, 32'h14, 32'h66, rdata, alignErr, latency);
        checkOutput("prio rdata", rdata, 32'd0);
        readWord("prio", 32'h14, 32'h66);

        // Reset during WAIT discards the pending write and never pulses Ready.
        writeWord("t5", 32'h10, 32'h3);
        @(negedge clk);
        busIf.MemWrite  = 1'b1;
        busIf.MemRead   = 1'b1;
        busIf.DataAdr   = 32'h10;
        busIf.WriteData = 32'h55;
        @(negedge clk);
        checkOutput("t5 wait ready", {31'd0, busIf.Ready}, 32'd0);
        reset          = 1'b0;
        busIf.MemWrite = 1'b0;
        busIf.MemRead  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t5 abort ready", {31'd0, busIf.Ready}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5 after reset ready", {31'd0, busIf.Ready}, 32'd0);
        checkOutput("t5 after reset done", {31'd0, busIf.Done}, 32'd0);
        readWord("t5", 32'h10, 32'h3);

        // tohost capture of the first store to address 100.
        writeWord("t6 first", 32'd100, 32'h7);
        @(negedge clk);
`ifdef DMEM_TOHOST_EN
        checkOutput("t6 done", {31'd0, busIf.Done}, 32'd1);
        checkOutput("t6 donevalue", busIf.DoneValue, 32'h7);
`else
        checkOutput("t6 done", {31'd0, busIf.Done}, 32'd0);
        checkOutput("t6 donevalue", busIf.DoneValue, 32'h0);
`endif
        writeWord("t6 second", 32'd100, 32'h9);
        @(negedge clk);
`ifdef DMEM_TOHOST_EN
        checkOutput("t6 done sticky", {31'd0, busIf.Done}, 32'd1);
        checkOutput("t6 donevalue kept", busIf.DoneValue, 32'h7);
`else
        checkOutput("t6 done sticky", {31'd0, busIf.Done}, 32'd0);
        checkOutput("t6 donevalue kept", busIf.DoneValue, 32'h0);
`endif
        readWord("t6", 32'd100, 32'h9);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
